// File: rtl/fetch_seq.sv
// ============================================================================
// fetch_seq : instruction fetch sequencer with redirect handling and a
//             one-entry output buffer. Optional macro: FETCH_ALIGN_CHECK_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fetch_seq #(
  parameter logic [31:0] PC_INITIAL = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        is_exception,
  input  logic [31:0] exception_new_pc,
  input  logic        is_branch,
  input  logic [31:0] branch_address,
  input  logic        stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;

  logic        r_buf_valid;
  logic [31:0] r_buf_pc, r_buf_inst;
  logic        w_buf_load;
  logic [31:0] w_buf_pc, w_buf_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_buf_adel;
  logic        w_buf_adel;
`endif

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_consume;
  logic        w_buf_free;

  // Exception outranks branch when both fire in the same cycle.
  assign w_redirect = is_exception | is_branch;
  assign w_target   = is_exception ? exception_new_pc : branch_address;
  assign w_consume  = r_buf_valid & ~stall;
  assign w_buf_free = ~r_buf_valid | w_consume;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_pc          <= PC_INITIAL;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
      r_fetch_pc    <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_buf_load        = 1'b0;
    w_buf_pc          = r_pc;
    w_buf_inst        = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_buf_adel        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (w_buf_free) begin
`ifdef FETCH_ALIGN_CHECK_EN
          // Misaligned PC becomes a fault entry instead of a bus request.
          if (r_pc[1:0] != 2'b00) begin
            w_buf_load = 1'b1;
            w_buf_adel = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
`else
          w_state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        if (inst_addr_ok) begin
          if (w_redirect) begin
            w_pc_nxt         = w_target;
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = DROP;
          end else if (r_pend_valid) begin
            w_pc_nxt         = r_pend_target;
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = DROP;
          end else begin
            w_fetch_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + 32'd4;
            w_state_nxt    = WAIT;
          end
        end else if (w_redirect) begin
          // Address must stay stable on the bus; remember the redirect.
          w_pend_valid_nxt  = 1'b1;
          w_pend_target_nxt = w_target;
        end
      end
      WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = inst_data_ok ? IDLE : DROP;
        end else if (inst_data_ok) begin
          w_buf_load  = 1'b1;
          w_buf_pc    = r_fetch_pc;
          w_buf_inst  = inst_rdata;
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (w_redirect) w_pc_nxt = w_target;
        if (inst_data_ok) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'h0;
      r_buf_inst  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_buf_adel  <= 1'b0;
`endif
    end else if (w_redirect) begin
      r_buf_valid <= 1'b0;
    end else if (w_buf_load) begin
      r_buf_valid <= 1'b1;
      r_buf_pc    <= w_buf_pc;
      r_buf_inst  <= w_buf_inst;
`ifdef FETCH_ALIGN_CHECK_EN
      r_buf_adel  <= w_buf_adel;
`endif
    end else if (w_consume) begin
      r_buf_valid <= 1'b0;
    end
  end

  assign inst_req  = (r_state == REQ);
  assign inst_addr = r_pc;
  assign if_valid  = r_buf_valid;
  assign if_pc     = r_buf_pc;
  assign if_inst   = r_buf_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  assign if_adel   = r_buf_adel;
`else
  assign if_adel   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq; bus handshakes are driven by hand.
`default_nettype none

module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        is_exception;
  logic [31:0] exception_new_pc;
  logic        is_branch;
  logic [31:0] branch_address;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int errors = 0;
  int checks = 0;

  fetch_seq dut (
    .clk              (clk),
    .resetn           (resetn),
    .is_exception     (is_exception),
    .exception_new_pc (exception_new_pc),
    .is_branch        (is_branch),
    .branch_address   (branch_address),
    .stall            (stall),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_adel          (if_adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!inst_req && n < 20) begin
      step();
      n++;
    end
    ok = inst_req;
  endtask

  task automatic do_addr();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] d);
    inst_data_ok = 1'b1;
    inst_rdata   = d;
    step();
    inst_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    is_branch = 1'b1; branch_address = 32'h12345678;
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hffffffff;
    step(); step(); step();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", inst_req); end
    checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL reset_addr: got %h want bfc00000", inst_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL reset_buf: pc=%h inst=%h want 0/0", if_pc, if_inst); end
    checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %0b want 0", if_adel); end
    is_branch = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    resetn = 1'b1;
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'hbfc00000 + 32'(4 * i);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_req%0d: inst_req=%0b want 1", i, inst_req); end
      checks++; if (inst_addr !== a) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, inst_addr, a); end
      do_addr();
      do_data(32'h1000_0000 + 32'(i));
      checks++;
      if (if_valid !== 1'b1 || if_pc !== a || if_inst !== 32'h1000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL seq_buf%0d: v=%0b pc=%h inst=%h want 1 %h %h", i, if_valid, if_pc, if_inst, a, 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    wait_req(ok);
    checks++; if (!ok || inst_addr !== 32'hbfc0000c) begin errors++; $display("FAIL stall_req: req=%0b addr=%h want 1 bfc0000c", inst_req, inst_addr); end
    stall = 1'b1;
    do_addr();
    do_data(32'hcafe0001);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'hbfc0000c || if_inst !== 32'hcafe0001 || inst_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%0b pc=%h inst=%h req=%0b want 1 bfc0000c cafe0001 0", i, if_valid, if_pc, if_inst, inst_req);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin errors++; $display("FAIL stall_release: req=%0b addr=%h want 1 bfc00010", inst_req, inst_addr); end
    do_addr();
    do_data(32'hcafe0002);
  endtask

  task automatic test_branch_wait();
    bit ok;
    wait_req(ok);
    do_addr();
    is_branch = 1'b1; branch_address = 32'h80001000;
    step();
    is_branch = 1'b0;
    checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL br_drop: req=%0b v=%0b want 0 0", inst_req, if_valid); end
    step();
    do_data(32'hdeadbeef);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_discard: v=%0b want 0", if_valid); end
    wait_req(ok);
    checks++; if (!ok || inst_addr !== 32'h80001000) begin errors++; $display("FAIL br_addr: req=%0b addr=%h want 1 80001000", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0001);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80001000 || if_inst !== 32'h0bad0001) begin errors++; $display("FAIL br_buf: v=%0b pc=%h inst=%h want 1 80001000 0bad0001", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_exc_branch();
    bit ok;
    wait_req(ok);
    is_exception = 1'b1; exception_new_pc = 32'hbfc00380;
    is_branch = 1'b1; branch_address = 32'h80000000;
    step();
    is_exception = 1'b0; is_branch = 1'b0;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h80001004) begin errors++; $display("FAIL exc_hold: req=%0b addr=%h want 1 80001004", inst_req, inst_addr); end
    do_addr();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL exc_drop: req=%0b want 0", inst_req); end
    do_data(32'h5a5a5a5a);
    wait_req(ok);
    checks++; if (!ok || inst_addr !== 32'hbfc00380) begin errors++; $display("FAIL exc_addr: req=%0b addr=%h want 1 bfc00380", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0002);
    checks++; if (if_pc !== 32'hbfc00380 || if_inst !== 32'h0bad0002) begin errors++; $display("FAIL exc_buf: pc=%h inst=%h want bfc00380 0bad0002", if_pc, if_inst); end
  endtask

  task automatic test_wrap();
    bit ok;
    wait_req(ok);
    is_branch = 1'b1; branch_address = 32'hfffffffc; inst_addr_ok = 1'b1;
    step();
    is_branch = 1'b0; inst_addr_ok = 1'b0;
    do_data(32'h11111111);
    wait_req(ok);
    checks++; if (!ok || inst_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_top: req=%0b addr=%h want 1 fffffffc", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0003);
    checks++; if (if_pc !== 32'hfffffffc || if_inst !== 32'h0bad0003) begin errors++; $display("FAIL wrap_buf: pc=%h inst=%h want fffffffc 0bad0003", if_pc, if_inst); end
    wait_req(ok);
    checks++; if (!ok || inst_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_zero: req=%0b addr=%h want 1 00000000", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0004);
  endtask

  task automatic test_misaligned();
    bit ok;
    wait_req(ok);
    is_branch = 1'b1; branch_address = 32'h80000002; inst_addr_ok = 1'b1;
    step();
    is_branch = 1'b0; inst_addr_ok = 1'b0;
    do_data(32'h22222222);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (inst_req !== 1'b0 || if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'h80000002 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL adel_entry: req=%0b v=%0b adel=%0b pc=%h inst=%h want 0 1 1 80000002 0", inst_req, if_valid, if_adel, if_pc, if_inst);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (inst_req !== 1'b0 || if_valid !== 1'b1) begin errors++; $display("FAIL adel_noreq%0d: req=%0b v=%0b want 0 1", i, inst_req, if_valid); end
    end
    is_branch = 1'b1; branch_address = 32'hbfc00000;
    step();
    is_branch = 1'b0; stall = 1'b0;
    step();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL adel_recover: req=%0b addr=%h want 1 bfc00000", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0005);
`else
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h80000002) begin errors++; $display("FAIL mis_req: req=%0b addr=%h want 1 80000002", inst_req, inst_addr); end
    do_addr();
    do_data(32'h0bad0005);
    checks++; if (if_adel !== 1'b0 || if_pc !== 32'h80000002 || if_inst !== 32'h0bad0005) begin errors++; $display("FAIL mis_buf: adel=%0b pc=%h inst=%h want 0 80000002 0bad0005", if_adel, if_pc, if_inst); end
`endif
  endtask

  task automatic test_reset_midflight();
    bit ok;
    wait_req(ok);
    do_addr();
    resetn = 1'b0;
    step();
    checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0 || inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL mid_reset: req=%0b v=%0b addr=%h want 0 0 bfc00000", inst_req, if_valid, inst_addr); end
    resetn = 1'b1;
    step();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL mid_restart: req=%0b addr=%h want 1 bfc00000", inst_req, inst_addr); end
  endtask

  initial begin
    resetn = 1'b0; is_exception = 1'b0; exception_new_pc = 32'h0;
    is_branch = 1'b0; branch_address = 32'h0; stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_exc_branch();
    test_wrap();
    test_misaligned();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter PC_INITIAL, default 32'hbfc00000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 Port resetn  input  1  reset, synchronous, active-low.
REQ-004 Port is_exception  input  1  exception redirect request, single-cycle.
REQ-005 Port exception_new_pc  input  32  exception target, valid with is_exception.
REQ-006 Port is_branch  input  1  branch redirect request, single-cycle.
REQ-007 Port branch_address  input  32  branch target, valid with is_branch.
REQ-008 Port stall  input  1  decode stage not accepting the buffered instruction.
REQ-009 Port inst_req  output  1  instruction-bus request.
REQ-010 Port inst_addr  output  32  request address; equals the fetch PC.
REQ-011 Port inst_addr_ok  input  1  bus accepted the address this cycle.
REQ-012 Port inst_data_ok  input  1  read data valid this cycle.
REQ-013 Port inst_rdata  input  32  read data.
REQ-014 Port if_valid  output  1  output buffer holds an instruction.
REQ-015 Port if_pc  output  32  PC of the buffered instruction.
REQ-016 Port if_inst  output  32  buffered instruction word.
REQ-017 Port if_adel  output  1  buffered entry is a misaligned-fetch fault.

Function
REQ-018 The block SHALL have states IDLE, REQ, WAIT, DROP, a 32-bit fetch PC, a pending-redirect register (valid + target) and a one-entry output buffer (if_valid/if_pc/if_inst/if_adel).
REQ-019 Redirect this cycle = is_exception | is_branch; target SHALL be exception_new_pc if is_exception else branch_address (exception wins when both are asserted).
REQ-020 Any redirect SHALL clear the output buffer (if_valid=0 next cycle) in the same cycle.
REQ-021 Buffer is consumed when if_valid=1 and stall=0; "buffer free" = !if_valid or consumed this cycle.
REQ-022 IDLE: redirect -> PC<=target, stay IDLE; else if buffer free -> REQ; else stay.
REQ-023 REQ: inst_req=1 with inst_addr=PC held stable until inst_addr_ok; a request is never withdrawn.
REQ-024 A redirect in REQ without inst_addr_ok SHALL set pending (valid, target); a later redirect overwrites the pending target.
REQ-025 REQ with inst_addr_ok: if a redirect this cycle or pending valid -> PC<=newest target, clear pending, go DROP; else latch fetched PC, PC<=PC+4, go WAIT.
REQ-026 WAIT: inst_data_ok without redirect -> buffer<=(fetched PC, inst_rdata, adel=0), go IDLE; inst_data_ok with redirect -> discard data, PC<=target, go IDLE.
REQ-027 WAIT: redirect without inst_data_ok -> PC<=target, go DROP.
REQ-028 DROP: inst_data_ok -> discard data, go IDLE; a redirect in DROP SHALL update PC<=target and is honoured regardless of inst_data_ok.
REQ-029 At most one bus transaction SHALL be outstanding; inst_req=0 in IDLE, WAIT and DROP.
REQ-030 PC+4 SHALL wrap modulo 2^32 (32'hfffffffc -> 32'h00000000).
REQ-031 The buffer SHALL never be overwritten while valid and not consumed.

Reset
REQ-032 resetn=0 at posedge SHALL set state=IDLE, PC=PC_INITIAL, pending cleared, if_valid=0, if_pc=0, if_inst=0, if_adel=0, inst_req=0, overriding all inputs.
REQ-033 Reset mid-transaction SHALL abandon it; the bus is responsible for suppressing the stale data_ok after reset.

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: in IDLE with buffer free and PC[1:0]!=0, no bus request is issued; buffer<=(PC, 32'h0, adel=1), PC holds until a redirect.
REQ-035 FETCH_ALIGN_CHECK_EN undefined: if_adel SHALL be constant 0 and misaligned PCs are requested as normal.

Verification
REQ-036 Reset release, addr_ok and data_ok each 1 cycle after request, stall=0 -> inst_addr 32'hbfc00000, bfc00004, bfc00008 in order; if_pc matches.
REQ-037 stall=1 held 5 cycles with a full buffer -> if_valid, if_pc and if_inst stable; no new inst_req until stall drops.
REQ-038 Branch to 32'h80001000 in WAIT, data_ok 2 cycles later -> old data dropped; next inst_addr=32'h80001000.
REQ-039 is_exception (32'hbfc00380) and is_branch (32'h80000000) in the same REQ cycle before addr_ok -> after DROP, next request addr=32'hbfc00380.
REQ-040 With FETCH_ALIGN_CHECK_EN, branch to 32'h80000002 -> no inst_req; if_valid=1, if_adel=1, if_pc=32'h80000002, if_inst=0.
REQ-041 Force PC=32'hfffffffc, complete a fetch -> next inst_addr=32'h00000000.
